phy_reg_ready_table: RTL and testbench
======================================

# phy_reg_ready_table

Per-physical-register readiness scoreboard, directly downstream of `execute_feedback`. It consumes the merged `execute_feedback_pack` each cycle and marks destination physical registers ready. Rename allocations mark registers not-ready. The issue/readreg stages query it to decide operand readiness, with same-cycle feedback bypass so a wakeup is never delayed an extra cycle.

## Interface
- `PHY_REG_NUM`, default 128: number of physical registers; power of two.
- `EXECUTE_UNIT_NUM`, default `` `EXECUTE_UNIT_NUM ``: feedback channels in `execute_feedback_pack`.
- `RENAME_WIDTH`, default 4: allocation ports per cycle.
- `QUERY_NUM`, default 8: query ports (2 per issued instruction × 4).
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `execute_feedback_pack`, input, `execute_feedback_pack_t`: uses `channel[i].enable` and `channel[i].phy_id`; `value` is ignored.
- `rename_alloc_valid`, input, `[RENAME_WIDTH]`: allocation port i is valid.
- `rename_alloc_phy_id`, input, `[RENAME_WIDTH]×log2(PHY_REG_NUM)`: newly allocated destination register.
- `flush`, input, 1: pipeline flush; restores all entries to ready.
- `query_phy_id`, input, `[QUERY_NUM]×log2(PHY_REG_NUM)`: registers to test.
- `query_ready`, output, `[QUERY_NUM]`: combinational readiness per query.
- `ready_count`, output, log2(PHY_REG_NUM)+1: registered count of ready entries.

## Operation
- State: `ready_table[PHY_REG_NUM]` of flops. `ready_count` is a flop.
- Per entry, next-state priority, highest first:
  - `flush` sets the entry to 1.
  - Entry 0 is always 1. Allocation of phy 0 is ignored.
  - Any valid allocation port with matching id sets the entry to 0.
  - Any feedback channel with `enable`=1 and matching id sets the entry to 1.
  - Otherwise the entry holds.
- Clear-beats-set: if allocation and feedback hit the same id in one cycle, the entry goes to 0.
- Duplicate ids across allocation ports, across feedback channels, or both are legal. Results are idempotent.
- `query_ready[q]` = `ready_table[query_phy_id[q]]` OR (some channel `enable` && `phy_id`==`query_phy_id[q]`).
  - Allocation in the same cycle is not visible to queries; it shows only from the next cycle.
  - Flush in the same cycle is not visible to queries.
- `ready_count` next = popcount of `ready_table` next-state. It therefore always equals the popcount of the table in the same cycle. No saturation is needed because the range is 0..PHY_REG_NUM.
- Flush recovery rule: killed in-flight destinations become ready. Re-allocation clears them again. This is architecturally safe because freed registers are never read before re-allocation.

## Timing
- Reset (async assert, sync-safe deassert):
  - all `ready_table` entries = 1.
  - `ready_count` = PHY_REG_NUM (128).
  - `query_ready` reflects the table, so all ones.
- Allocation at cycle N: entry reads 0 from cycle N+1.
- Feedback at cycle N: `query_ready` is 1 in cycle N through the bypass, and the entry is 1 from cycle N+1.
- Flush at cycle N: all entries are 1 from N+1. Allocation and feedback in cycle N are discarded.
- `rst` asserted mid-operation: table and count return to reset values immediately, regardless of `clk`.
- No handshakes; every input is sampled every cycle. There are no stalls and no back-pressure.

## Test plan
- Reset with all inputs 0:
  - `ready_count`=128.
  - query ids 0..7 all give `query_ready`=1.
- Allocate phy 5, 6, 7, 0 in one cycle:
  - next cycle `query_ready` for 5/6/7=0 and for 0=1.
  - `ready_count`=125.
- Feedback on phy 6:
  - `query_ready` for 6 is 1 in the same cycle.
  - the entry is set the next cycle.
  - `ready_count`=126.
  - querying 5 in that cycle still gives 0.
- Same cycle: allocate phy 9 and feedback phy 9 (entry 9 initially 1):
  - entry 9 becomes 0 next cycle.
  - `ready_count` decrements by 1.
- Allocate 20 registers over 5 cycles (`ready_count`=108), then assert `flush` together with allocation of phy 30:
  - next cycle all queries give 1, including 30.
  - `ready_count`=128.
- Allocate phy 40, then assert `rst` between clock edges:
  - `ready_count`=128 and entry 40 = 1 before the next edge.
  - normal allocation works after deassert.

Source files
------------

// File: rtl/phy_reg_ready_table_if.sv
// Bundle between the rename/issue/execute stages and the physical register
// readiness scoreboard. The scoreboard side uses the slave modport.
`ifndef EXECUTE_UNIT_NUM
`define EXECUTE_UNIT_NUM 4
`endif

interface phy_reg_ready_table_if #(
  parameter int PHY_REG_NUM          = 128,
  parameter int EXECUTE_UNIT_NUM     = `EXECUTE_UNIT_NUM,
  parameter int RENAME_WIDTH         = 4,
  parameter int QUERY_NUM            = 8,
  parameter int FEEDBACK_VALUE_WIDTH = 32
);
  localparam int PHY_ID_W = $clog2(PHY_REG_NUM);

  // One execute writeback channel; only enable/phy_id matter for readiness.
  typedef struct packed {
    logic                            enable;
    logic [PHY_ID_W-1:0]             phy_id;
    logic [FEEDBACK_VALUE_WIDTH-1:0] value;
  } execute_feedback_channel_t;

  typedef struct packed {
    execute_feedback_channel_t [EXECUTE_UNIT_NUM-1:0] channel;
  } execute_feedback_pack_t;

  execute_feedback_pack_t                      execute_feedback_pack;
  logic [RENAME_WIDTH-1:0]                     rename_alloc_valid;
  logic [RENAME_WIDTH-1:0][PHY_ID_W-1:0]       rename_alloc_phy_id;
  logic                                        flush;
  logic [QUERY_NUM-1:0][PHY_ID_W-1:0]          query_phy_id;
  logic [QUERY_NUM-1:0]                        query_ready;
  logic [PHY_ID_W:0]                           ready_count;

  modport master (
    output execute_feedback_pack,
    output rename_alloc_valid,
    output rename_alloc_phy_id,
    output flush,
    output query_phy_id,
    input  query_ready,
    input  ready_count
  );

  modport slave (
    input  execute_feedback_pack,
    input  rename_alloc_valid,
    input  rename_alloc_phy_id,
    input  flush,
    input  query_phy_id,
    output query_ready,
    output ready_count
  );
endinterface

// File: rtl/phy_reg_ready_table.sv
// Per-physical-register readiness scoreboard. Rename allocations clear an
// entry, execute feedback sets it, flush sets everything. Queries see the
// registered table OR'd with same-cycle feedback so wakeups are not delayed.
`ifndef EXECUTE_UNIT_NUM
`define EXECUTE_UNIT_NUM 4
`endif

module phy_reg_ready_table #(
  parameter int PHY_REG_NUM      = 128,
  parameter int EXECUTE_UNIT_NUM = `EXECUTE_UNIT_NUM,
  parameter int RENAME_WIDTH     = 4,
  parameter int QUERY_NUM        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  phy_reg_ready_table_if.slave bus
);
  localparam int PHY_ID_W = $clog2(PHY_REG_NUM);
  localparam int CNT_W    = PHY_ID_W + 1;

  logic [PHY_REG_NUM-1:0]                    ready_table_r;
  logic [PHY_REG_NUM-1:0]                    ready_next_s;
  logic [CNT_W-1:0]                          ready_count_r;
  logic [EXECUTE_UNIT_NUM-1:0]               fb_enable_s;
  logic [EXECUTE_UNIT_NUM-1:0][PHY_ID_W-1:0] fb_phy_id_s;
  logic [QUERY_NUM-1:0]                      query_ready_s;
  logic                                      unused_value_s;

  // Number of set bits in a table image.
  function automatic logic [CNT_W-1:0] popcount(input logic [PHY_REG_NUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < PHY_REG_NUM; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // True when any enabled feedback channel targets the given register.
  function automatic logic bypass_hit(
    input logic [EXECUTE_UNIT_NUM-1:0]               en,
    input logic [EXECUTE_UNIT_NUM-1:0][PHY_ID_W-1:0] ids,
    input logic [PHY_ID_W-1:0]                       id
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < EXECUTE_UNIT_NUM; i++) begin
      hit = hit | (en[i] & (ids[i] == id));
    end
    return hit;
  endfunction

  // The feedback value payload has no bearing on readiness.
  assign unused_value_s = ^bus.execute_feedback_pack;

  // Flatten the feedback channels into plain enable/id vectors.
  always_comb begin
    fb_enable_s = '0;
    fb_phy_id_s = '0;
    for (int i = 0; i < EXECUTE_UNIT_NUM; i++) begin
      fb_enable_s[i] = bus.execute_feedback_pack.channel[i].enable;
      fb_phy_id_s[i] = bus.execute_feedback_pack.channel[i].phy_id;
    end
  end

  // Next table: feedback sets, allocation clears afterwards (clear beats
  // set), flush overrides both, and entry 0 is pinned ready.
  always_comb begin
    ready_next_s = ready_table_r;
    if (bus.flush) begin
      ready_next_s = '1;
    end else begin
      for (int i = 0; i < EXECUTE_UNIT_NUM; i++) begin
        ready_next_s[fb_phy_id_s[i]] = ready_next_s[fb_phy_id_s[i]] | fb_enable_s[i];
      end
      for (int r = 0; r < RENAME_WIDTH; r++) begin
        ready_next_s[bus.rename_alloc_phy_id[r]] =
          ready_next_s[bus.rename_alloc_phy_id[r]] & ~bus.rename_alloc_valid[r];
      end
    end
    ready_next_s[0] = 1'b1;
  end

  // Table and count update; count tracks the popcount of the new table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_table_r <= '1;
      ready_count_r <= CNT_W'(PHY_REG_NUM);
    end else begin
      ready_table_r <= ready_next_s;
      ready_count_r <= popcount(ready_next_s);
    end
  end

  // Query lookup with same-cycle feedback bypass; allocation and flush in
  // the current cycle are deliberately not visible here.
  always_comb begin
    query_ready_s = '0;
    for (int q = 0; q < QUERY_NUM; q++) begin
      query_ready_s[q] = ready_table_r[bus.query_phy_id[q]] |
                         bypass_hit(fb_enable_s, fb_phy_id_s, bus.query_phy_id[q]);
    end
  end

  assign bus.query_ready = query_ready_s;
  assign bus.ready_count = ready_count_r;

endmodule

// File: tb/tb_phy_reg_ready_table.sv
// Directed, table-driven bench for the physical register readiness table.
module tb_phy_reg_ready_table;
  localparam int PRN = 128;
  localparam int EU  = 4;
  localparam int RW  = 4;
  localparam int QN  = 8;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  phy_reg_ready_table_if #(
    .PHY_REG_NUM(PRN), .EXECUTE_UNIT_NUM(EU), .RENAME_WIDTH(RW), .QUERY_NUM(QN)
  ) bus ();

  phy_reg_ready_table #(
    .PHY_REG_NUM(PRN), .EXECUTE_UNIT_NUM(EU), .RENAME_WIDTH(RW), .QUERY_NUM(QN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      av;
    logic [3:0][6:0] aid;
    logic [3:0]      fe;
    logic [3:0][6:0] fid;
    logic            fl;
    logic [7:0][6:0] qid;
    logic [7:0]      exp_q;
    logic [7:0]      exp_cnt;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [3:0][6:0] p4(input int a0, input int a1, input int a2, input int a3);
    logic [3:0][6:0] r;
    r[0] = 7'(a0); r[1] = 7'(a1); r[2] = 7'(a2); r[3] = 7'(a3);
    return r;
  endfunction

  function automatic logic [7:0][6:0] p8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    logic [7:0][6:0] r;
    r[0] = 7'(a0); r[1] = 7'(a1); r[2] = 7'(a2); r[3] = 7'(a3);
    r[4] = 7'(a4); r[5] = 7'(a5); r[6] = 7'(a6); r[7] = 7'(a7);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    for (int i = 0; i < EU; i++) begin
      bus.execute_feedback_pack.channel[i].enable = v.fe[i];
      bus.execute_feedback_pack.channel[i].phy_id = v.fid[i];
      bus.execute_feedback_pack.channel[i].value  = 32'hA5A5_0000 + 32'(i);
    end
    bus.rename_alloc_valid  = v.av;
    bus.rename_alloc_phy_id = v.aid;
    bus.flush               = v.fl;
    bus.query_phy_id        = v.qid;
  endtask

  function automatic vec_t mk(input logic [3:0] av, input logic [3:0][6:0] aid,
                              input logic [3:0] fe, input logic [3:0][6:0] fid,
                              input logic fl, input logic [7:0][6:0] qid);
    vec_t v;
    v.av = av; v.aid = aid; v.fe = fe; v.fid = fid; v.fl = fl; v.qid = qid;
    v.exp_q = 8'h00; v.exp_cnt = 8'h00;
    return v;
  endfunction

  initial begin
    vec_t v;
    pass_cnt  = 0;
    total_cnt = 0;

    // Expected values worked out by hand from the readiness rules.
    vecs[0] = '{av:4'b1111, aid:p4(5,6,7,0), fe:4'b0000, fid:p4(0,0,0,0), fl:1'b0,
                qid:p8(0,1,2,3,4,5,6,7), exp_q:8'hFF, exp_cnt:8'd125};
    vecs[1] = '{av:4'b0000, aid:p4(0,0,0,0), fe:4'b0001, fid:p4(6,0,0,0), fl:1'b0,
                qid:p8(5,6,7,0,1,2,3,4), exp_q:8'hFA, exp_cnt:8'd126};
    vecs[2] = '{av:4'b0000, aid:p4(0,0,0,0), fe:4'b0000, fid:p4(0,0,0,0), fl:1'b0,
                qid:p8(5,6,7,0,1,2,3,4), exp_q:8'hFA, exp_cnt:8'd126};
    vecs[3] = '{av:4'b0001, aid:p4(9,0,0,0), fe:4'b0010, fid:p4(0,9,0,0), fl:1'b0,
                qid:p8(9,5,6,7,0,1,2,3), exp_q:8'hF5, exp_cnt:8'd125};
    vecs[4] = '{av:4'b0000, aid:p4(0,0,0,0), fe:4'b0000, fid:p4(0,0,0,0), fl:1'b0,
                qid:p8(9,5,6,7,0,1,2,3), exp_q:8'hF4, exp_cnt:8'd125};
    vecs[5] = '{av:4'b1111, aid:p4(12,12,12,12), fe:4'b0011, fid:p4(13,13,0,0), fl:1'b0,
                qid:p8(12,13,9,5,6,7,0,1), exp_q:8'hD3, exp_cnt:8'd124};
    vecs[6] = '{av:4'b0000, aid:p4(0,0,0,0), fe:4'b0111, fid:p4(12,7,7,0), fl:1'b0,
                qid:p8(12,7,5,9,0,1,2,3), exp_q:8'hF3, exp_cnt:8'd126};
    vecs[7] = '{av:4'b0001, aid:p4(0,0,0,0), fe:4'b0001, fid:p4(0,0,0,0), fl:1'b0,
                qid:p8(0,12,7,5,9,1,2,3), exp_q:8'hE7, exp_cnt:8'd126};

    // Reset with all inputs idle.
    rst = 1'b1;
    drive(mk(4'b0, p4(0,0,0,0), 4'b0, p4(0,0,0,0), 1'b0, p8(0,1,2,3,4,5,6,7)));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_count", 32'(bus.ready_count), 32'd128);
    check("reset_query", 32'(bus.query_ready), 32'hFF);

    // Vector table: query checked inside the cycle, count after the edge.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      check($sformatf("vec%0d_query", k), 32'(bus.query_ready), 32'(vecs[k].exp_q));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", k), 32'(bus.ready_count), 32'(vecs[k].exp_cnt));
    end

    // Flush restores everything; same-cycle query still sees old table.
    @(negedge clk);
    drive(mk(4'b0001, p4(20,0,0,0), 4'b0, p4(0,0,0,0), 1'b1, p8(5,9,0,1,2,3,4,6)));
    #1;
    check("flush1_query_same", 32'(bus.query_ready), 32'hFC);
    @(posedge clk);
    #1;
    check("flush1_count", 32'(bus.ready_count), 32'd128);

    // Allocate 20 registers (32..51) over 5 cycles.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(mk(4'b1111, p4(32+4*c, 33+4*c, 34+4*c, 35+4*c), 4'b0, p4(0,0,0,0), 1'b0,
               p8(0,0,0,0,0,0,0,0)));
    end
    @(posedge clk);
    #1;
    check("alloc20_count", 32'(bus.ready_count), 32'd108);

    // Flush together with allocation of 30.
    @(negedge clk);
    drive(mk(4'b0001, p4(30,0,0,0), 4'b0, p4(0,0,0,0), 1'b1, p8(32,33,34,35,36,37,38,39)));
    #1;
    check("flush2_query_same", 32'(bus.query_ready), 32'h00);
    @(posedge clk);
    #1;
    check("flush2_count", 32'(bus.ready_count), 32'd128);
    @(negedge clk);
    drive(mk(4'b0, p4(0,0,0,0), 4'b0, p4(0,0,0,0), 1'b0, p8(30,32,33,34,35,36,51,9)));
    #1;
    check("flush2_query_after", 32'(bus.query_ready), 32'hFF);

    // Allocate 40, then assert reset between clock edges.
    @(negedge clk);
    drive(mk(4'b0001, p4(40,0,0,0), 4'b0, p4(0,0,0,0), 1'b0, p8(40,0,0,0,0,0,0,0)));
    @(posedge clk);
    #1;
    drive(mk(4'b0, p4(0,0,0,0), 4'b0, p4(0,0,0,0), 1'b0, p8(40,0,0,0,0,0,0,0)));
    #1;
    check("alloc40_count", 32'(bus.ready_count), 32'd127);
    check("alloc40_query", 32'(bus.query_ready[0]), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(bus.ready_count), 32'd128);
    check("midrst_query", 32'(bus.query_ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(mk(4'b0001, p4(41,0,0,0), 4'b0, p4(0,0,0,0), 1'b0, p8(41,40,0,0,0,0,0,0)));
    @(posedge clk);
    #1;
    v = mk(4'b0, p4(0,0,0,0), 4'b0, p4(0,0,0,0), 1'b0, p8(41,40,0,0,0,0,0,0));
    drive(v);
    #1;
    check("post_rst_count", 32'(bus.ready_count), 32'd127);
    check("post_rst_query", 32'(bus.query_ready[1:0]), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
